mc_cu: RTL and testbench

//  Multicycle control unit for the MIPS-subset CPU; parametrised successor to the single-cycle control unit.

---
 rtl/mc_cu_pkg.sv | 82 ++++++++
 rtl/mc_cu_decode.sv | 50 +++++
 rtl/mc_cu.sv | 171 +++++++++++++++++
 tb/tb_mc_cu.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_cu_pkg.sv
// mc_cu_pkg: shared definitions for the multicycle control unit.
//   state_t   - FSM state encodings (IF/ID/EXE/MEM/WB/TRAP), also exported on the debug port
//   OP_*/FN_* - opcode and R-type function field constants
//   ALU_*     - ALU operation codes (low four bits of aluc)
//   ASB_*     - ALU B operand select encodings
//   PCS_*     - next-PC source select encodings
//   dec_t     - decoded instruction: per-instruction flags, class bits, legality, ALU code
package mc_cu_pkg;

  typedef enum logic [2:0] {
    S_IF   = 3'd0,
    S_ID   = 3'd1,
    S_EXE  = 3'd2,
    S_MEM  = 3'd3,
    S_WB   = 3'd4,
    S_TRAP = 3'd5
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_XOR  = 6'b100110;
  localparam logic [5:0] FN_SLL  = 6'b000000;
  localparam logic [5:0] FN_SRL  = 6'b000010;
  localparam logic [5:0] FN_SRA  = 6'b000011;
  localparam logic [5:0] FN_JR   = 6'b001000;
  localparam logic [5:0] FN_HAMD = 6'b001001;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0100;
  localparam logic [3:0] ALU_AND  = 4'b0001;
  localparam logic [3:0] ALU_OR   = 4'b0101;
  localparam logic [3:0] ALU_XOR  = 4'b0010;
  localparam logic [3:0] ALU_LUI  = 4'b0110;
  localparam logic [3:0] ALU_SLL  = 4'b0011;
  localparam logic [3:0] ALU_SRL  = 4'b0111;
  localparam logic [3:0] ALU_SRA  = 4'b1111;
  localparam logic [3:0] ALU_HAMD = 4'b1000;

  localparam logic [1:0] ASB_REG    = 2'b00;
  localparam logic [1:0] ASB_FOUR   = 2'b01;
  localparam logic [1:0] ASB_IMM    = 2'b10;
  localparam logic [1:0] ASB_BRANCH = 2'b11;

  localparam logic [1:0] PCS_ALU    = 2'b00;
  localparam logic [1:0] PCS_BRANCH = 2'b01;
  localparam logic [1:0] PCS_RS     = 2'b10;
  localparam logic [1:0] PCS_JUMP   = 2'b11;

  typedef struct packed {
    logic       rtype;   // class: R-format (op 000000)
    logic       imm;     // class: I-type ALU op (addi/andi/ori/xori/lui)
    logic       mem;     // class: lw or sw
    logic       branch;  // class: beq or bne
    logic       jump;    // class: j, jal or jr
    logic       lw;
    logic       sw;
    logic       beq;
    logic       bne;
    logic       jal;
    logic       jr;
    logic       shift;   // ALU A takes the shift amount
    logic       sext;    // immediate is sign-extended in EXE
    logic       legal;
    logic [3:0] alu;
  } dec_t;

endpackage

// File: rtl/mc_cu_decode.sv
// mc_cu_decode: combinational instruction decoder.
//   op, func - instruction opcode and R-type function fields
//   dec      - decoded flags, class bits, legality and ALU operation
module mc_cu_decode
  import mc_cu_pkg::*;
#(
  parameter bit EN_HAMD = 1'b1
) (
  input  logic [5:0] op,
  input  logic [5:0] func,
  output dec_t       dec
);

  always_comb begin
    dec     = '0;
    dec.alu = ALU_ADD;
    case (op)
      OP_RTYPE: begin
        dec.rtype = 1'b1;
        dec.legal = 1'b1;
        case (func)
          FN_ADD:  dec.alu = ALU_ADD;
          FN_SUB:  dec.alu = ALU_SUB;
          FN_AND:  dec.alu = ALU_AND;
          FN_OR:   dec.alu = ALU_OR;
          FN_XOR:  dec.alu = ALU_XOR;
          FN_SLL:  begin dec.alu = ALU_SLL; dec.shift = 1'b1; end
          FN_SRL:  begin dec.alu = ALU_SRL; dec.shift = 1'b1; end
          FN_SRA:  begin dec.alu = ALU_SRA; dec.shift = 1'b1; end
          FN_JR:   begin dec.jump = 1'b1; dec.jr = 1'b1; end
          FN_HAMD: begin dec.alu = ALU_HAMD; dec.legal = EN_HAMD; end
          default: dec.legal = 1'b0;
        endcase
      end
      OP_ADDI: begin dec.imm = 1'b1; dec.sext = 1'b1; dec.legal = 1'b1; end
      OP_ANDI: begin dec.imm = 1'b1; dec.alu = ALU_AND; dec.legal = 1'b1; end
      OP_ORI:  begin dec.imm = 1'b1; dec.alu = ALU_OR;  dec.legal = 1'b1; end
      OP_XORI: begin dec.imm = 1'b1; dec.alu = ALU_XOR; dec.legal = 1'b1; end
      OP_LUI:  begin dec.imm = 1'b1; dec.alu = ALU_LUI; dec.legal = 1'b1; end
      OP_LW:   begin dec.mem = 1'b1; dec.lw = 1'b1; dec.sext = 1'b1; dec.legal = 1'b1; end
      OP_SW:   begin dec.mem = 1'b1; dec.sw = 1'b1; dec.sext = 1'b1; dec.legal = 1'b1; end
      OP_BEQ:  begin dec.branch = 1'b1; dec.beq = 1'b1; dec.sext = 1'b1; dec.alu = ALU_SUB; dec.legal = 1'b1; end
      OP_BNE:  begin dec.branch = 1'b1; dec.bne = 1'b1; dec.sext = 1'b1; dec.alu = ALU_SUB; dec.legal = 1'b1; end
      OP_J:    begin dec.jump = 1'b1; dec.legal = 1'b1; end
      OP_JAL:  begin dec.jump = 1'b1; dec.jal = 1'b1; dec.legal = 1'b1; end
      default: dec.legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/mc_cu.sv
// mc_cu: multicycle control unit (IF/ID/EXE/MEM/WB plus TRAP).
//   clk, rst          - clock and synchronous active-high reset
//   op, func, z       - IR fields and ALU zero flag
//   mem_ready/mem_req - shared memory handshake; iord selects PC or ALU address
//   wmem, wir, wpc, wreg            - write enables (forced low while rst is high)
//   regrt, m2reg, jal, shift, sext  - datapath steering
//   alusrca, alusrcb, aluc, pcsource - ALU operand/op and next-PC selects
//   state             - current FSM state (debug)
//   err               - sticky trap flag (illegal instruction or memory timeout)
module mc_cu
  import mc_cu_pkg::*;
#(
  parameter int unsigned ALUC_W       = 4,
  parameter bit          EN_HAMD      = 1'b1,
  parameter int unsigned MEM_WAIT_MAX = 15,
  parameter int unsigned CNT_W        = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [5:0]        op,
  input  logic [5:0]        func,
  input  logic              z,
  input  logic              mem_ready,
  output logic              mem_req,
  output logic              iord,
  output logic              wmem,
  output logic              wir,
  output logic              wpc,
  output logic              wreg,
  output logic              regrt,
  output logic              m2reg,
  output logic              jal,
  output logic              shift,
  output logic              sext,
  output logic              alusrca,
  output logic [1:0]        alusrcb,
  output logic [ALUC_W-1:0] aluc,
  output logic [1:0]        pcsource,
  output logic [2:0]        state,
  output logic              err
);

  localparam logic [CNT_W-1:0] WAIT_LIM = CNT_W'(MEM_WAIT_MAX);

  state_t           cur;
  state_t           nxt;
  logic             err_q;
  logic [CNT_W-1:0] cnt;
  dec_t             dec;
  logic             mem_phase;
  logic             wait_hit;
  logic [3:0]       alu_op;

  mc_cu_decode #(.EN_HAMD(EN_HAMD)) u_decode (
    .op   (op),
    .func (func),
    .dec  (dec)
  );

  // Timeout fires only on a stalled cycle; a ready arriving at the limit wins.
  always_comb begin
    mem_phase = (cur == S_IF) || (cur == S_MEM);
    wait_hit  = (MEM_WAIT_MAX != 0) && mem_phase && !mem_ready && (cnt == WAIT_LIM);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cur   <= S_IF;
      err_q <= 1'b0;
      cnt   <= '0;
    end else begin
      cur <= nxt;
      if (nxt == S_TRAP) err_q <= 1'b1;
      if (mem_phase && !mem_ready && (nxt == cur)) cnt <= cnt + CNT_W'(1);
      else                                         cnt <= '0;
    end
  end

  always_comb begin
    nxt      = cur;
    mem_req  = 1'b0;
    iord     = 1'b0;
    wmem     = 1'b0;
    wir      = 1'b0;
    wpc      = 1'b0;
    wreg     = 1'b0;
    regrt    = 1'b0;
    m2reg    = 1'b0;
    jal      = 1'b0;
    shift    = 1'b0;
    sext     = 1'b0;
    alusrca  = 1'b0;
    alusrcb  = ASB_REG;
    alu_op   = ALU_ADD;
    pcsource = PCS_ALU;
    case (cur)
      S_IF: begin
        mem_req = 1'b1;
        alusrcb = ASB_FOUR;
        if (mem_ready) begin
          wir = 1'b1;
          wpc = 1'b1;
          nxt = S_ID;
        end else if (wait_hit) begin
          nxt = S_TRAP;
        end
      end
      S_ID: begin
        alusrcb = ASB_BRANCH;
        sext    = 1'b1;
        if (!dec.legal) begin
          nxt = S_TRAP;
        end else if (dec.jump) begin
          wpc      = 1'b1;
          pcsource = dec.jr ? PCS_RS : PCS_JUMP;
          wreg     = dec.jal;
          jal      = dec.jal;
          nxt      = S_IF;
        end else begin
          nxt = S_EXE;
        end
      end
      S_EXE: begin
        alusrca = 1'b1;
        shift   = dec.shift;
        sext    = dec.sext;
        alusrcb = (dec.imm || dec.mem) ? ASB_IMM : ASB_REG;
        alu_op  = dec.alu;
        if (dec.branch) begin
          pcsource = PCS_BRANCH;
          wpc      = (dec.beq && z) || (dec.bne && !z);
          nxt      = S_IF;
        end else if (dec.mem) begin
          nxt = S_MEM;
        end else begin
          nxt = S_WB;
        end
      end
      S_MEM: begin
        mem_req = 1'b1;
        iord    = 1'b1;
        wmem    = dec.sw;
        if (mem_ready)     nxt = dec.sw ? S_IF : S_WB;
        else if (wait_hit) nxt = S_TRAP;
      end
      S_WB: begin
        wreg  = 1'b1;
        m2reg = dec.lw;
        regrt = !dec.rtype;
        nxt   = S_IF;
      end
      S_TRAP:  nxt = S_TRAP;
      default: nxt = S_IF;
    endcase
    if (rst) begin
      mem_req = 1'b0;
      wmem    = 1'b0;
      wir     = 1'b0;
      wpc     = 1'b0;
      wreg    = 1'b0;
    end
    aluc        = '0;
    aluc[3:0]   = alu_op;
  end

  always_comb begin
    state = cur;
    err   = err_q;
  end

endmodule

// File: tb/tb_mc_cu.sv
// tb_mc_cu: self-checking bench for mc_cu. Three instances:
//   dut0 defaults, dut1 EN_HAMD=0, dut2 MEM_WAIT_MAX=3.
// Each instruction is expanded into its expected phase trace, then played
// cycle by cycle with outputs compared against per-phase expectations.
module tb_mc_cu;

  localparam int NI = 3;

  function automatic bit hamd_cfg(int k);
    return k != 1;
  endfunction

  function automatic int unsigned wait_cfg(int k);
    return (k == 2) ? 3 : 15;
  endfunction

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst [NI];
  logic [5:0] op [NI];
  logic [5:0] func [NI];
  logic       z [NI];
  logic       mem_ready [NI];
  logic       mem_req [NI], iord [NI], wmem [NI], wir [NI], wpc [NI], wreg [NI];
  logic       regrt [NI], m2reg [NI], jal [NI], shift [NI], sext [NI], alusrca [NI], err [NI];
  logic [1:0] alusrcb [NI], pcsource [NI];
  logic [3:0] aluc [NI];
  logic [2:0] state [NI];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    mc_cu #(
      .ALUC_W       (4),
      .EN_HAMD      (hamd_cfg(g)),
      .MEM_WAIT_MAX (wait_cfg(g)),
      .CNT_W        (4)
    ) u_dut (
      .clk       (clk),
      .rst       (rst[g]),
      .op        (op[g]),
      .func      (func[g]),
      .z         (z[g]),
      .mem_ready (mem_ready[g]),
      .mem_req   (mem_req[g]),
      .iord      (iord[g]),
      .wmem      (wmem[g]),
      .wir       (wir[g]),
      .wpc       (wpc[g]),
      .wreg      (wreg[g]),
      .regrt     (regrt[g]),
      .m2reg     (m2reg[g]),
      .jal       (jal[g]),
      .shift     (shift[g]),
      .sext      (sext[g]),
      .alusrca   (alusrca[g]),
      .alusrcb   (alusrcb[g]),
      .aluc      (aluc[g]),
      .pcsource  (pcsource[g]),
      .state     (state[g]),
      .err       (err[g])
    );
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef enum {K_ALU, K_LW, K_SW, K_BR, K_J, K_JAL, K_JR, K_BAD} kind_e;
  typedef struct {
    kind_e    kind;
    bit       imm;
    bit       shft;
    bit       is_beq;
    bit [3:0] alu;
  } ref_t;
  typedef struct {
    int unsigned ph;
    bit          rdy;
  } step_t;

  step_t q[$];

  function automatic ref_t classify(bit [5:0] o, bit [5:0] f, bit hamd);
    ref_t r;
    r.kind = K_ALU; r.imm = 0; r.shft = 0; r.is_beq = 0; r.alu = 4'b0000;
    case (o)
      6'h00: case (f)
        6'h20: r.alu = 4'b0000;
        6'h22: r.alu = 4'b0100;
        6'h24: r.alu = 4'b0001;
        6'h25: r.alu = 4'b0101;
        6'h26: r.alu = 4'b0010;
        6'h00: begin r.alu = 4'b0011; r.shft = 1; end
        6'h02: begin r.alu = 4'b0111; r.shft = 1; end
        6'h03: begin r.alu = 4'b1111; r.shft = 1; end
        6'h08: r.kind = K_JR;
        6'h09: if (hamd) r.alu = 4'b1000; else r.kind = K_BAD;
        default: r.kind = K_BAD;
      endcase
      6'h08: r.imm = 1;
      6'h0c: begin r.imm = 1; r.alu = 4'b0001; end
      6'h0d: begin r.imm = 1; r.alu = 4'b0101; end
      6'h0e: begin r.imm = 1; r.alu = 4'b0010; end
      6'h0f: begin r.imm = 1; r.alu = 4'b0110; end
      6'h23: r.kind = K_LW;
      6'h2b: r.kind = K_SW;
      6'h04: begin r.kind = K_BR; r.is_beq = 1; r.alu = 4'b0100; end
      6'h05: begin r.kind = K_BR; r.alu = 4'b0100; end
      6'h02: r.kind = K_J;
      6'h03: r.kind = K_JAL;
      default: r.kind = K_BAD;
    endcase
    return r;
  endfunction

  function automatic bit rnd_bit();
    return 1'($urandom_range(0, 1));
  endfunction

  // Memory phase: 'lows' stalled cycles then ready, unless the limit trips first.
  function automatic bit add_wait(int unsigned ph, int unsigned lows, int unsigned wmax);
    if (wmax != 0 && lows > wmax) begin
      for (int unsigned i = 0; i <= wmax; i++) q.push_back('{ph, 1'b0});
      q.push_back('{5, rnd_bit()});
      return 1'b1;
    end
    for (int unsigned i = 0; i < lows; i++) q.push_back('{ph, 1'b0});
    q.push_back('{ph, 1'b1});
    return 1'b0;
  endfunction

  function automatic bit build(ref_t r, int unsigned ifw, int unsigned memw, int unsigned wmax);
    bit t;
    q.delete();
    t = add_wait(0, ifw, wmax);
    if (!t) begin
      q.push_back('{1, rnd_bit()});
      case (r.kind)
        K_BAD: begin q.push_back('{5, rnd_bit()}); t = 1; end
        K_BR:  q.push_back('{2, rnd_bit()});
        K_ALU: begin q.push_back('{2, rnd_bit()}); q.push_back('{4, rnd_bit()}); end
        K_LW: begin
          q.push_back('{2, rnd_bit()});
          t = add_wait(3, memw, wmax);
          if (!t) q.push_back('{4, rnd_bit()});
        end
        K_SW: begin
          q.push_back('{2, rnd_bit()});
          t = add_wait(3, memw, wmax);
        end
        default: ;
      endcase
    end
    if (t) begin
      q.push_back('{5, rnd_bit()});
      q.push_back('{5, rnd_bit()});
    end
    return t;
  endfunction

  task automatic check_step(int k, step_t s, ref_t r, bit zz);
    bit [4:0] en;
    bit       taken;
    bit       jmp;
    string    p;
    p     = $sformatf("dut%0d ph%0d", k, s.ph);
    taken = (r.kind == K_BR) && (r.is_beq ? zz : !zz);
    jmp   = r.kind inside {K_J, K_JAL, K_JR};
    case (s.ph)
      0: en = {1'b1, 1'b0, s.rdy, s.rdy, 1'b0};
      1: en = {3'b000, jmp, r.kind == K_JAL};
      2: en = {3'b000, taken, 1'b0};
      3: en = {1'b1, r.kind == K_SW, 3'b000};
      4: en = 5'b00001;
      default: en = 5'b00000;
    endcase
    chk({p, " state"}, 32'(state[k]), s.ph);
    chk({p, " err"}, 32'(err[k]), 32'(s.ph == 5));
    chk({p, " req/wmem/wir/wpc/wreg"}, {mem_req[k], wmem[k], wir[k], wpc[k], wreg[k]}, 32'(en));
    case (s.ph)
      0: begin
        chk({p, " iord"}, 32'(iord[k]), 0);
        if (s.rdy)
          chk({p, " pc4 mux"}, {alusrca[k], alusrcb[k], aluc[k], pcsource[k]}, {1'b0, 2'b01, 4'b0000, 2'b00});
      end
      1: begin
        chk({p, " id mux"}, {alusrca[k], alusrcb[k], sext[k], aluc[k]}, {1'b0, 2'b11, 1'b1, 4'b0000});
        chk({p, " jal"}, 32'(jal[k]), 32'(r.kind == K_JAL));
        if (jmp) chk({p, " pcsource"}, 32'(pcsource[k]), (r.kind == K_JR) ? 2 : 3);
      end
      2: begin
        chk({p, " exe mux"}, {alusrca[k], shift[k], alusrcb[k], aluc[k]},
            {1'b1, r.shft, (r.imm || r.kind inside {K_LW, K_SW}) ? 2'd2 : 2'd0, r.alu});
        if (taken) chk({p, " pcsource"}, 32'(pcsource[k]), 1);
      end
      3: chk({p, " iord"}, 32'(iord[k]), 1);
      4: chk({p, " wb m2reg/regrt"}, {m2reg[k], regrt[k]},
             {r.kind == K_LW, r.imm || (r.kind == K_LW)});
      default: ;
    endcase
  endtask

  // Called at posedge+1; leaves the bench at posedge+1.
  task automatic do_reset(int k);
    rst[k] = 1'b1;
    mem_ready[k] = 1'b1;
    @(negedge clk);
    chk($sformatf("dut%0d rst enables", k), {mem_req[k], wmem[k], wir[k], wpc[k], wreg[k]}, 0);
    @(posedge clk); #1;
    rst[k] = 1'b0;
    #1;
    chk($sformatf("dut%0d rst state", k), 32'(state[k]), 0);
    chk($sformatf("dut%0d rst err", k), 32'(err[k]), 0);
  endtask

  task automatic run_instr(int k, bit [5:0] o, bit [5:0] f, bit zz, int unsigned ifw, int unsigned memw);
    ref_t r;
    bit   t;
    r = classify(o, f, hamd_cfg(k));
    t = build(r, ifw, memw, wait_cfg(k));
    op[k] = o; func[k] = f; z[k] = zz;
    foreach (q[i]) begin
      mem_ready[k] = q[i].rdy;
      @(negedge clk);
      check_step(k, q[i], r, zz);
      @(posedge clk); #1;
    end
    if (t) do_reset(k);
  endtask

  function automatic bit [11:0] legal_enc(int i);
    case (i)
      0: return {6'h00, 6'h20};  1: return {6'h00, 6'h22};  2: return {6'h00, 6'h24};
      3: return {6'h00, 6'h25};  4: return {6'h00, 6'h26};  5: return {6'h00, 6'h00};
      6: return {6'h00, 6'h02};  7: return {6'h00, 6'h03};  8: return {6'h00, 6'h08};
      9: return {6'h00, 6'h09}; 10: return {6'h08, 6'h15}; 11: return {6'h0c, 6'h3f};
     12: return {6'h0d, 6'h01}; 13: return {6'h0e, 6'h2a}; 14: return {6'h23, 6'h10};
     15: return {6'h2b, 6'h07}; 16: return {6'h04, 6'h11}; 17: return {6'h05, 6'h00};
     18: return {6'h0f, 6'h05}; 19: return {6'h02, 6'h33}; default: return {6'h03, 6'h1c};
    endcase
  endfunction

  task automatic rand_run(int k, int n);
    bit [11:0]   enc;
    int unsigned ifw, memw;
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 9) < 8) enc = legal_enc(int'($urandom_range(0, 20)));
      else                          enc = 12'($urandom);
      ifw  = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 5) : $urandom_range(0, 1);
      memw = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 5) : $urandom_range(0, 1);
      run_instr(k, enc[11:6], enc[5:0], rnd_bit(), ifw, memw);
    end
  endtask

  initial begin
    for (int k = 0; k < NI; k++) begin
      rst[k] = 1'b1; op[k] = 6'h02; func[k] = '0; z[k] = 1'b0; mem_ready[k] = 1'b1;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < NI; k++) begin
      chk($sformatf("dut%0d reset enables", k), {mem_req[k], wmem[k], wir[k], wpc[k], wreg[k]}, 0);
      chk($sformatf("dut%0d reset state", k), 32'(state[k]), 0);
      chk($sformatf("dut%0d reset err", k), 32'(err[k]), 0);
    end
    @(posedge clk); #1;

    // default configuration
    rst[0] = 1'b0;
    run_instr(0, 6'h00, 6'h20, 1'b0, 0, 0);   // add
    run_instr(0, 6'h23, 6'h00, 1'b0, 0, 3);   // lw, three stalled MEM cycles
    run_instr(0, 6'h04, 6'h00, 1'b1, 0, 0);   // beq taken
    run_instr(0, 6'h04, 6'h00, 1'b0, 0, 0);   // beq not taken
    run_instr(0, 6'h05, 6'h00, 1'b0, 0, 0);   // bne taken
    run_instr(0, 6'h03, 6'h00, 1'b0, 0, 0);   // jal
    run_instr(0, 6'h00, 6'h08, 1'b0, 0, 0);   // jr
    run_instr(0, 6'h00, 6'h09, 1'b0, 0, 0);   // hamd legal here
    run_instr(0, 6'h2b, 6'h00, 1'b0, 1, 2);   // sw
    run_instr(0, 6'h0c, 6'h00, 1'b0, 15, 0);  // ready on the limit cycle
    run_instr(0, 6'h0d, 6'h00, 1'b0, 16, 0);  // one stall too many
    // reset abandons a j in ID; the jump's wpc must not fire
    op[0] = 6'h02; mem_ready[0] = 1'b1;
    @(negedge clk);
    chk("dut0 midrst IF state", 32'(state[0]), 0);
    @(posedge clk); #1;
    do_reset(0);
    rand_run(0, 40);
    rst[0] = 1'b1;

    // hamd disabled
    rst[1] = 1'b0;
    run_instr(1, 6'h00, 6'h09, 1'b0, 0, 0);
    run_instr(1, 6'h00, 6'h22, 1'b0, 0, 0);
    rand_run(1, 30);
    rst[1] = 1'b1;

    // short memory timeout
    rst[2] = 1'b0;
    run_instr(2, 6'h00, 6'h20, 1'b0, 3, 0);
    run_instr(2, 6'h00, 6'h20, 1'b0, 4, 0);
    run_instr(2, 6'h2b, 6'h00, 1'b0, 0, 3);
    run_instr(2, 6'h23, 6'h00, 1'b0, 0, 4);
    rand_run(2, 40);
    rst[2] = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
